alu_result_display: RTL

Result consumer for the 3-bit ALU. It accepts one ALU result per load pulse together with its flags and operation select. It converts the value to sign plus two BCD digits with a sequential double-dabble and drives a time-multiplexed 4-digit 7-segment display. It sits between the ALU outputs and the board display/LED pins.

---
 rtl/alu_result_display.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_result_display.sv
// ALU result to sign + 2-digit BCD (5-step double-dabble) driving a scanned 4-digit 7-seg display.
// Display/LEDs update 6 edges after load; load ignored while busy; optional DISPLAY_BLINK_EN blinks the error pattern.
module alu_result_display #(
  parameter int REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] result,
  input  logic [1:0] sel,
  input  logic       zeroFlag,
  input  logic       divByZeroFlag,
  output logic       busy,
  output logic       ack,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       zero_led,
  output logic       err_led
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       ITERS   = 3'd5;

  localparam logic [6:0] GLYPH_MINUS = 7'h40;
  localparam logic [6:0] GLYPH_E     = 7'h79;
  localparam logic [6:0] GLYPH_R     = 7'h50;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  state_e           state_q, state_d;
  logic [4:0]       mag_q, mag_d;
  logic [7:0]       bcd_q, bcd_d;
  logic [2:0]       iter_q, iter_d;
  logic             neg_q, neg_d;
  logic             cap_zero_q, cap_zero_d;
  logic             cap_err_q, cap_err_d;
  logic [3:0][6:0]  disp_q, disp_d;
  logic             zero_led_q, zero_led_d;
  logic             err_led_q, err_led_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic             accept;
  logic             conv_step;
  logic             disp_wr;
  logic             scan_wrap;
  logic [3:0]       ones_adj, tens_adj;
  logic [12:0]      shifted;

  assign accept    = (state_q == IDLE) && load;
  assign conv_step = (state_q == CONV) && (iter_q != ITERS);
  assign disp_wr   = (state_q == CONV) && (iter_q == ITERS);
  assign scan_wrap = (scan_cnt_q == CNT_MAX);

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = CONV;
      CONV:    if (iter_q == ITERS) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != IDLE);
    ack  = (state_q == DONE);
  end

  // Capture and double-dabble: adjust nibbles >= 5 by +3, then shift the whole chain left.
  always_comb begin
    ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    shifted  = {tens_adj, ones_adj, mag_q} << 1;

    mag_d      = mag_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    neg_d      = neg_q;
    cap_zero_d = cap_zero_q;
    cap_err_d  = cap_err_q;

    if (accept) begin
      neg_d      = (sel == 2'b01) && result[4];
      mag_d      = neg_d ? (~result + 5'd1) : result;
      bcd_d      = 8'h00;
      iter_d     = 3'd0;
      cap_zero_d = zeroFlag;
      cap_err_d  = divByZeroFlag;
    end else if (conv_step) begin
      bcd_d  = shifted[12:5];
      mag_d  = shifted[4:0];
      iter_d = iter_q + 3'd1;
    end
  end

  // Display registers and LEDs load together on the edge entering DONE.
  always_comb begin
    disp_d     = disp_q;
    zero_led_d = zero_led_q;
    err_led_d  = err_led_q;
    if (disp_wr) begin
      zero_led_d = cap_zero_q;
      err_led_d  = cap_err_q;
      if (cap_err_q) begin
        disp_d[3] = GLYPH_E;
        disp_d[2] = GLYPH_R;
        disp_d[1] = GLYPH_R;
        disp_d[0] = GLYPH_BLANK;
      end else begin
        disp_d[3] = neg_q ? GLYPH_MINUS : GLYPH_BLANK;
        disp_d[2] = GLYPH_BLANK;
        disp_d[1] = (bcd_q[7:4] == 4'd0) ? GLYPH_BLANK : digit_glyph(bcd_q[7:4]);
        disp_d[0] = digit_glyph(bcd_q[3:0]);
      end
    end
  end

  always_comb begin
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + CNT_W'(1);
    idx_d      = scan_wrap ? idx_q + 2'd1 : idx_q;
    an_d       = 4'b0001 << idx_d;
  end

`ifdef DISPLAY_BLINK_EN
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       blink_ph_q, blink_ph_d;
  logic       disp_err_q, disp_err_d;

  always_comb begin
    blink_cnt_d = scan_wrap ? blink_cnt_q + 8'd1 : blink_cnt_q;
    blink_ph_d  = (scan_wrap && (blink_cnt_q == 8'hFF)) ? ~blink_ph_q : blink_ph_q;
    disp_err_d  = disp_wr ? cap_err_q : disp_err_q;
    seg_d       = (disp_err_d && blink_ph_d) ? GLYPH_BLANK : disp_d[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= 8'h00;
      blink_ph_q  <= 1'b0;
      disp_err_q  <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      disp_err_q  <= disp_err_d;
    end
  end
`else
  always_comb begin
    seg_d = disp_d[idx_d];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q      <= 5'd0;
      bcd_q      <= 8'h00;
      iter_q     <= 3'd0;
      neg_q      <= 1'b0;
      cap_zero_q <= 1'b0;
      cap_err_q  <= 1'b0;
      disp_q     <= '0;
      zero_led_q <= 1'b0;
      err_led_q  <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      seg_q      <= GLYPH_BLANK;
      an_q       <= 4'b0001;
    end else begin
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      neg_q      <= neg_d;
      cap_zero_q <= cap_zero_d;
      cap_err_q  <= cap_err_d;
      disp_q     <= disp_d;
      zero_led_q <= zero_led_d;
      err_led_q  <= err_led_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign zero_led = zero_led_q;
  assign err_led  = err_led_q;

endmodule
